// File: rtl/mnist_pkg.sv
// mnist_pkg: constants and types shared by the MNIST pixel front end.
//   N_PIX_DEF / PIX_W_DEF / ADDR_W_DEF : default frame geometry (28x28, 8-bit)
//   pixel_t / pix_addr_t               : pixel value and in-frame pixel index
//   rd_state_t                         : reader-side ownership state
package mnist_pkg;

    localparam int IMG_DIM    = 28;
    localparam int N_PIX_DEF  = 784;
    localparam int PIX_W_DEF  = 8;
    localparam int ADDR_W_DEF = 10;

    typedef logic [PIX_W_DEF-1:0]  pixel_t;
    typedef logic [ADDR_W_DEF-1:0] pix_addr_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_BUSY = 1'b1
    } rd_state_t;

endpackage

// File: rtl/frame_bank_ram.sv
// frame_bank_ram: single-clock simple dual-port RAM holding one frame.
//   clk, rst          : clock; async active-high reset (read register only)
//   we/wr_addr/wr_data: write port
//   rd_addr/rd_data   : registered read port, 1-cycle latency;
//                       addresses >= DEPTH read as 0
module frame_bank_ram #(
    parameter int DEPTH  = 784,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage has no reset so it maps onto block RAM; the writer never
    // presents an address beyond DEPTH-1.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Output register carries the reset so rd_data is 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          rd_data <= '0;
        else if (int'(rd_addr) < DEPTH)   rd_data <= mem[rd_addr];
        else                              rd_data <= '0;
    end

endmodule

// File: rtl/pixel_frame_buffer.sv
// pixel_frame_buffer: packs an 8-bit pixel stream into N_PIX-pixel frames in a
// two-bank ping-pong buffer and hands each complete frame to a random-access
// reader, so the streamer can run ahead by one frame.
//   clk, rst            : single clock; async active-high reset
//   data_in/valid_in    : pixel stream; ready_in = current write bank not full
//   frame_valid         : reader owns a complete frame
//   rd_addr/rd_data     : read port into the owned frame, 1-cycle latency
//   frame_done          : 1-cycle pulse, reader releases its frame
//   frame_count         : frames completed since reset (wraps)
//   overflow            : sticky, a pixel arrived while ready_in=0
// Build option: define PIX_THRESH_EN to binarise pixels against THRESH on write.
module pixel_frame_buffer
    import mnist_pkg::*;
#(
    parameter int N_PIX  = N_PIX_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 16,
    parameter int THRESH = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  data_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic              frame_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    input  logic              frame_done,
    output logic [CNT_W-1:0]  frame_count,
    output logic              overflow
);

    // Reject geometries the address counter or threshold cannot represent.
    if ((64'd1 << ADDR_W) < 64'(N_PIX) || THRESH < 0 || (64'(THRESH) >> PIX_W) != 0) begin : g_bad_cfg
        $error("pixel_frame_buffer: bad N_PIX/ADDR_W/THRESH combination");
    end

    logic [ADDR_W-1:0]       wr_idx;
    logic                    wr_bank;
    logic                    rd_bank;
    logic                    rd_sel_q;
    logic [1:0]              full;
    logic [1:0]              full_set;
    logic [1:0]              full_clr;
    logic                    accept;
    logic                    last_pix;
    logic                    release_frame;
    logic [PIX_W-1:0]        wr_pix;
    logic [1:0][PIX_W-1:0]   bank_q;
    rd_state_t               state;
    rd_state_t               state_nxt;

    assign ready_in = ~full[wr_bank];
    assign accept   = valid_in & ready_in;
    assign last_pix = (wr_idx == ADDR_W'(N_PIX - 1));

`ifdef PIX_THRESH_EN
    assign wr_pix = (data_in >= PIX_W'(THRESH)) ? '1 : '0;
`else
    assign wr_pix = data_in;
`endif

    // ---------------- write side ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx      <= '0;
            wr_bank     <= 1'b0;
            frame_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (accept) begin
                if (last_pix) begin
                    wr_idx      <= '0;
                    wr_bank     <= ~wr_bank;
                    frame_count <= frame_count + 1'b1;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            if (valid_in && !ready_in) overflow <= 1'b1;
        end
    end

    // Writer and reader always sit on different banks whenever the reader's
    // bank is full, so a set and a clear in the same cycle never collide.
    assign full_set = (accept && last_pix) ? (2'b01 << wr_bank) : 2'b00;
    assign full_clr = release_frame        ? (2'b01 << rd_bank) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) full <= 2'b00;
        else     full <= (full | full_set) & ~full_clr;
    end

    // ---------------- read side FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RD_IDLE;
            rd_bank <= 1'b0;
        end else begin
            state <= state_nxt;
            if (release_frame) rd_bank <= ~rd_bank;
        end
    end

    always_comb begin
        state_nxt     = state;
        frame_valid   = 1'b0;
        release_frame = 1'b0;
        case (state)
            RD_IDLE: begin
                if (full[rd_bank]) state_nxt = RD_BUSY;
            end
            RD_BUSY: begin
                frame_valid = 1'b1;
                if (frame_done) begin
                    release_frame = 1'b1;
                    state_nxt     = RD_IDLE;
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    // ---------------- banks ----------------
    for (genvar b = 0; b < 2; b++) begin : g_bank
        frame_bank_ram #(
            .DEPTH  (N_PIX),
            .DATA_W (PIX_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk     (clk),
            .rst     (rst),
            .we      (accept && (wr_bank == 1'(b))),
            .wr_addr (wr_idx),
            .wr_data (wr_pix),
            .rd_addr (rd_addr),
            .rd_data (bank_q[b])
        );
    end

    // Both banks are read every cycle; the mux select is delayed one cycle so
    // it matches the bank that produced the registered data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_sel_q <= 1'b0;
        else     rd_sel_q <= rd_bank;
    end

    assign rd_data = bank_q[rd_sel_q];

endmodule

// File: tb/tb_pixel_frame_buffer.sv
module tb_pixel_frame_buffer;
    import mnist_pkg::*;

    localparam int N = N_PIX_DEF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    pixel_t     data_in = '0;
    logic       valid_in = 1'b0;
    logic       ready_in;
    logic       frame_valid;
    pix_addr_t  rd_addr = '0;
    pixel_t     rd_data;
    logic       frame_done = 1'b0;
    logic [15:0] frame_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int addr;
        int exp;
    } rd_vec_t;

    rd_vec_t vecs [7];

    pixel_frame_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .frame_valid (frame_valid),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        valid_in   = 1'b0;
        frame_done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Stream n pixels back-to-back, value = base + i*inc (mod 256).
    task automatic stream(input int n, input int base, input int inc);
        for (int i = 0; i < n; i++) begin
            data_in  = pixel_t'(base + i * inc);
            valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
    endtask

    task automatic read_chk(input string name, input int addr, input int exp);
        rd_addr = pix_addr_t'(addr);
        step();
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0,    8'h00};
        vecs[1] = '{5,    8'h05};
        vecs[2] = '{783,  8'h0F};
        vecs[3] = '{255,  8'hFF};
        vecs[4] = '{256,  8'h00};
        vecs[5] = '{800,  8'h00};
        vecs[6] = '{1023, 8'h00};

        // ---- reset values ----
        step();
        chk("rst_ready",  32'(ready_in),    32'd1);
        chk("rst_fvalid", 32'(frame_valid), 32'd0);
        chk("rst_rddata", 32'(rd_data),     32'd0);
        chk("rst_count",  32'(frame_count), 32'd0);
        chk("rst_ovf",    32'(overflow),    32'd0);
        rst = 1'b0;

        // ---- single frame, value = index[7:0] ----
        stream(N, 0, 1);
        chk("f1_fv_same_cycle", 32'(frame_valid), 32'd0);
        chk("f1_count",         32'(frame_count), 32'd1);
        step();
        chk("f1_fv_rise",       32'(frame_valid), 32'd1);
        for (int i = 0; i < 7; i++)
            read_chk($sformatf("f1_rd_addr%0d", vecs[i].addr), vecs[i].addr, vecs[i].exp);
        pulse_done();
        chk("f1_fv_release", 32'(frame_valid), 32'd0);
        chk("f1_ready",      32'(ready_in),    32'd1);

        // ---- frame_done in IDLE is ignored ----
        pulse_done();
        step();
        chk("idle_done_fv", 32'(frame_valid), 32'd0);
        stream(N, 3, 1);
        step();
        chk("idle_done_fv2", 32'(frame_valid), 32'd1);
        read_chk("idle_done_rd0",   0,   8'h03);
        read_chk("idle_done_rd783", 783, 8'h12);
        chk("idle_done_count", 32'(frame_count), 32'd2);
        pulse_done();

        // ---- three frames back-to-back, no reader ----
        do_reset();
        stream(2 * N, 0, 1);
        chk("b2b_ready_low", 32'(ready_in),    32'd0);
        chk("b2b_ovf_pre",   32'(overflow),    32'd0);
        chk("b2b_count2",    32'(frame_count), 32'd2);
        stream(N, 0, 1);
        chk("b2b_ovf",       32'(overflow),    32'd1);
        chk("b2b_count_hold",32'(frame_count), 32'd2);
        chk("b2b_ready_hold",32'(ready_in),    32'd0);
        read_chk("b2b_f0_rd10", 10, 8'h0A);
        pulse_done();
        chk("b2b_ready_back", 32'(ready_in), 32'd1);
        step();
        chk("b2b_fv_f1", 32'(frame_valid), 32'd1);
        read_chk("b2b_f1_rd0",   0,   8'h10);
        read_chk("b2b_f1_rd783", 783, 8'h1F);
        chk("b2b_ovf_sticky", 32'(overflow), 32'd1);

        // ---- frame_done coincident with last pixel of next frame ----
        do_reset();
        stream(N, 0, 1);
        step();
        stream(N - 1, 8'h40, 1);
        data_in    = 8'h4F;
        valid_in   = 1'b1;
        frame_done = 1'b1;
        step();
        valid_in   = 1'b0;
        frame_done = 1'b0;
        chk("sim_ovf",   32'(overflow),    32'd0);
        chk("sim_gap",   32'(frame_valid), 32'd0);
        chk("sim_count", 32'(frame_count), 32'd2);
        chk("sim_ready", 32'(ready_in),    32'd1);
        step();
        chk("sim_fv", 32'(frame_valid), 32'd1);
        read_chk("sim_rd0",   0,   8'h40);
        read_chk("sim_rd100", 100, 8'hA4);
        read_chk("sim_rd783", 783, 8'h4F);

        // ---- reset mid-frame, then a fresh all-0xAA frame ----
        do_reset();
        stream(400, 0, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_count", 32'(frame_count), 32'd0);
        chk("mid_rst_fv",    32'(frame_valid), 32'd0);
        chk("mid_rst_ready", 32'(ready_in),    32'd1);
        stream(N, 8'hAA, 0);
        step();
        chk("aa_fv",    32'(frame_valid), 32'd1);
        chk("aa_count", 32'(frame_count), 32'd1);
        chk("aa_ovf",   32'(overflow),    32'd0);
        for (int a = 0; a < N; a++)
            read_chk($sformatf("aa_rd%0d", a), a, 8'hAA);

        // ---- threshold boundary pixels ----
        do_reset();
        data_in = 8'd127; valid_in = 1'b1; step();
        data_in = 8'd128; step();
        data_in = 8'd255; step();
        valid_in = 1'b0;
        stream(N - 3, 0, 0);
        step();
        chk("thr_fv", 32'(frame_valid), 32'd1);
`ifdef PIX_THRESH_EN
        read_chk("thr_127", 0, 8'h00);
        read_chk("thr_128", 1, 8'hFF);
        read_chk("thr_255", 2, 8'hFF);
`else
        read_chk("thr_127", 0, 8'd127);
        read_chk("thr_128", 1, 8'd128);
        read_chk("thr_255", 2, 8'd255);
`endif
        read_chk("thr_zero", 3, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
